// File: rtl/uart_defs.sv
// uart_defs: shared UART data width and send-sequencer state encodings
package uart_defs;
  localparam int UART_DATA_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single bit, async reset to 0
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clock or posedge reset)
    if (reset) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/tx_feed_ctrl.sv
// tx_feed_ctrl: byte FIFO and send sequencer feeding the UART transmitter
module tx_feed_ctrl
  import uart_defs::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   flush,
  input  logic                   enable,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   tx_send,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_active,
  input  logic                   tx_done
);
  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic act_s, done_s, wr_ok, pop, tx_send_d;
  logic [UART_DATA_W-1:0] tx_data_d;
  state_t state, state_d;

  sync_2ff u_sync_act  (.clock(clock), .reset(reset), .d(tx_active), .q(act_s));
  sync_2ff u_sync_done (.clock(clock), .reset(reset), .d(tx_done),   .q(done_s));

  assign count = wr_ptr - rd_ptr;
  assign full  = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign busy  = state != ST_IDLE;
  assign wr_ok = wr_en & ~full & ~flush;
  assign pop   = (state == ST_IDLE) & enable & ~empty;

  always_ff @(posedge clock)
    if (wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;

  // A write while full counts as overflow even if a pop frees a slot this cycle
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en & full) overflow <= 1'b1;
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state   <= ST_IDLE;
      tx_send <= 1'b0;
      tx_data <= '0;
    end else begin
      state   <= state_d;
      tx_send <= tx_send_d;
      tx_data <= tx_data_d;
    end

  always_comb begin
    state_d   = state;
    tx_send_d = tx_send;
    tx_data_d = tx_data;
    case (state)
      ST_IDLE: if (pop) begin
        state_d   = ST_SEND;
        tx_send_d = 1'b1;
        tx_data_d = mem[rd_ptr[ADDR_W-1:0]];
      end
      ST_SEND: if (act_s) begin
        state_d   = ST_DRAIN;
        tx_send_d = 1'b0;
      end
      ST_DRAIN: state_d = (!act_s && done_s) ? ST_GAP : ST_DRAIN;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_tx_feed_ctrl.sv
// tb_tx_feed_ctrl: directed vector table plus hand-written handshake sequences
module tb_tx_feed_ctrl;
  logic clock = 1'b0, reset = 1'b1, wr_en = 1'b0, flush = 1'b0, enable = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, empty, overflow, busy, tx_send, tx_active, tx_done;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic resp_act = 1'b0, resp_done = 1'b0, man_act = 1'b0, man_done = 1'b0, auto_tx = 1'b0;
  logic [7:0] rx_q [$];
  int checks = 0, failures = 0;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       fl;
    logic [4:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;
  vec_t v [23];

  assign tx_active = resp_act | man_act;
  assign tx_done   = resp_done | man_done;

  tx_feed_ctrl #(.DEPTH(16), .ADDR_W(4)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .enable(enable), .full(full), .empty(empty), .count(count), .overflow(overflow),
    .busy(busy), .tx_send(tx_send), .tx_data(tx_data), .tx_active(tx_active), .tx_done(tx_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Transmitter stand-in: takes a byte on tx_send, stays active a while, then pulses done
  initial forever begin
    @(negedge clock);
    if (auto_tx && tx_send && !resp_act) begin
      rx_q.push_back(tx_data);
      resp_act = 1'b1;
      repeat (6) @(negedge clock);
      resp_act  = 1'b0;
      resp_done = 1'b1;
      repeat (2) @(negedge clock);
      resp_done = 1'b0;
    end
  end

  initial begin
    v[0] = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    v[1] = '{1'b1, 8'h22, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
    v[2] = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
    v[3] = '{1'b1, 8'h33, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
    v[4] = '{1'b1, 8'h44, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    v[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 17; i++)
      v[6+i] = '{1'b1, 8'(i), 1'b0, 5'(i < 16 ? i + 1 : 16), i >= 15, 1'b0, i == 16};

    @(negedge clock);
    chk("reset_vals", 32'({full, empty, count, overflow, busy, tx_send, tx_data}),
        32'({1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00}));
    reset = 1'b0;
    step();

    enable = 1'b1;
    write_byte(8'hA5);
    chk("a5_after_write", 32'({tx_send, empty, count}), 32'({1'b0, 1'b0, 5'd1}));
    step();
    chk("a5_send", 32'({tx_send, tx_data, count}), 32'({1'b1, 8'hA5, 5'd0}));
    step();
    step();
    chk("a5_hold", 32'({tx_send, tx_data}), 32'({1'b1, 8'hA5}));
    man_act = 1'b1;
    step();
    chk("a5_act_sync1", 32'(tx_send), 32'd1);
    step();
    chk("a5_act_sync2", 32'(tx_send), 32'd1);
    step();
    chk("a5_send_drop", 32'({tx_send, busy}), 32'({1'b0, 1'b1}));
    man_act = 1'b0;
    man_done = 1'b1;
    wait_idle("a5_idle", 20);
    man_done = 1'b0;

    enable = 1'b0;
    for (int i = 0; i < 23; i++) begin
      wr_en = v[i].wr;
      wr_data = v[i].d;
      flush = v[i].fl;
      step();
      wr_en = 1'b0;
      flush = 1'b0;
      chk($sformatf("vec%0d", i), 32'({count, full, empty, overflow}),
          32'({v[i].cnt, v[i].full, v[i].empty, v[i].ovf}));
    end

    rx_q.delete();
    auto_tx = 1'b1;
    enable = 1'b1;
    begin
      int n = 0;
      while ((rx_q.size() < 16 || busy) && n < 1000) begin
        step();
        n++;
      end
    end
    chk("drain_count", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++)
      chk($sformatf("drain_byte%0d", i), 32'(rx_q[i]), 32'(i));
    chk("ovf_sticky", 32'({overflow, empty}), 32'({1'b1, 1'b1}));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_clr_ovf", 32'(overflow), 32'd0);

    enable = 1'b0;
    for (int i = 0; i < 5; i++) write_byte(8'h50 + 8'(i));
    chk("count5", 32'(count), 32'd5);
    enable = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    enable = 1'b0;
    chk("wr_pop_count5", 32'({count, busy}), 32'({5'd5, 1'b1}));
    wait_idle("wr_pop_idle", 100);

    for (int i = 0; i < 11; i++) write_byte(8'h60 + 8'(i));
    chk("full16", 32'({full, count, overflow}), 32'({1'b1, 5'd16, 1'b0}));
    enable = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    enable = 1'b0;
    chk("full_wr_pop", 32'({count, overflow, busy}), 32'({5'd15, 1'b1, 1'b1}));
    wait_idle("full_pop_idle", 100);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty", 32'({count, overflow, empty}), 32'({5'd0, 1'b0, 1'b1}));

    auto_tx = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    write_byte(8'h3C);
    step();
    chk("f_send3c", 32'({tx_send, tx_data}), 32'({1'b1, 8'h3C}));
    for (int i = 0; i < 4; i++) write_byte(8'h70 + 8'(i));
    chk("f_queued4", 32'(count), 32'd4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("f_after_flush", 32'({count, overflow, tx_send, tx_data}), 32'({5'd0, 1'b0, 1'b1, 8'h3C}));
    man_act = 1'b1;
    repeat (3) step();
    chk("f_send_drop", 32'(tx_send), 32'd0);
    man_act = 1'b0;
    man_done = 1'b1;
    wait_idle("f_idle", 20);
    man_done = 1'b0;
    repeat (10) step();
    chk("f_stays_idle", 32'({busy, tx_send, empty}), 32'({1'b0, 1'b0, 1'b1}));

    man_done = 1'b1;
    write_byte(8'h77);
    write_byte(8'h88);
    repeat (20) step();
    chk("stuck_send", 32'({tx_send, tx_data, count, busy}), 32'({1'b1, 8'h77, 5'd1, 1'b1}));
    man_act = 1'b1;
    begin
      int n = 0;
      while (tx_send && n < 20) begin
        step();
        n++;
      end
    end
    chk("drain_entered", 32'({tx_send, busy}), 32'({1'b0, 1'b1}));
    step();
    reset = 1'b1;
    #1;
    chk("reset_mid_drain", 32'({full, empty, count, overflow, busy, tx_send, tx_data}),
        32'({1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00}));
    man_act = 1'b0;
    man_done = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) step();
    chk("post_reset_quiet", 32'({tx_send, busy, empty}), 32'({1'b0, 1'b0, 1'b1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
